uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` transmitter among `N_REQ` byte-stream requesters. Each requester sends a frame of one or more bytes. The block grants frames round-robin and locks the transmitter to one owner for the whole frame. It drives the transmitter's `byte2send`/`tx_start` pair and consumes its `tx_done`. It sits between the application sources (command echo, status reporter, debug dump) and the single `uart_tx` instance in `top`.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one uart_tx among N_REQ byte streams
// A grant locks the transmitter to one requester until its last byte or a hold timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_req_last,
  input  logic [8*N_REQ-1:0]       i_req_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [7:0]               o_byte2send,
  output logic                     o_tx_start,
  input  logic                     i_tx_done,
  output logic [$clog2(N_REQ)-1:0] o_owner,
  output logic                     o_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_rr_ptr;
  logic [CW-1:0]     r_hold_cnt;
  logic              r_last;
  logic [IW-1:0]     r_owner;
  logic [7:0]        r_byte;
  logic [N_REQ-1:0]  r_ack;
  logic              r_tx_start;
  logic              r_busy;

  logic              w_grant_vld;
  logic [IW-1:0]     w_grant_idx;
  logic [IW-1:0]     w_owner_inc;
  logic [CW-1:0]     w_hold_inc;
  logic              w_load;
  logic [IW-1:0]     w_load_idx;
  logic [IW-1:0]     w_rr_nxt;
  logic [CW-1:0]     w_hold_nxt;
  logic              w_start_nxt;
  logic              w_busy_nxt;
  logic [N_REQ-1:0]  w_ack_nxt;

  function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IW-1:0];
  endfunction

  // Scan downward so the lowest offset from r_rr_ptr is the last (winning) assignment.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = wrap_idx(int'(r_rr_ptr), k);
      end
    end
  end

  assign w_owner_inc = wrap_idx(int'(r_owner), 1);
  assign w_hold_inc  = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_grant_vld) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_tx_done) w_state_nxt = r_last ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (i_req[r_owner])             w_state_nxt = S_START;
        else if (w_hold_inc == HOLD_LIM) w_state_nxt = S_IDLE;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they align with the state they describe.
  always_comb begin
    w_load     = 1'b0;
    w_load_idx = r_owner;
    w_rr_nxt   = r_rr_ptr;
    w_hold_nxt = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_load     = 1'b1;
          w_load_idx = w_grant_idx;
        end
      end
      S_WAIT_DONE: begin
        if (i_tx_done) begin
          if (r_last) w_rr_nxt   = w_owner_inc;
          else        w_hold_nxt = '0;
        end
      end
      S_HOLD: begin
        if (i_req[r_owner]) begin
          w_load = 1'b1;
        end else begin
          w_hold_nxt = w_hold_inc;
          if (w_hold_inc == HOLD_LIM) w_rr_nxt = w_owner_inc;
        end
      end
      default: ;
    endcase
    w_start_nxt = (w_state_nxt == S_START);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_ack_nxt   = '0;
    if (w_start_nxt) w_ack_nxt[w_load_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_last     <= 1'b0;
      r_owner    <= '0;
      r_byte     <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rr_ptr   <= w_rr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_start_nxt;
      r_busy     <= w_busy_nxt;
      if (w_load) begin
        r_owner <= w_load_idx;
        r_byte  <= i_req_data[{w_load_idx, 3'b000} +: 8];
        r_last  <= i_req_last[w_load_idx];
      end
    end
  end

  assign o_ack       = r_ack;
  assign o_tx_start  = r_tx_start;
  assign o_byte2send = r_byte;
  assign o_owner     = r_owner;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a frame-level round-robin model
// Stimulus loads per-requester byte queues; the model predicts issue order, a monitor checks each tx_start.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int HT = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [7:0]     byte2send;
  logic           tx_start;
  logic           tx_done;
  logic [1:0]     owner;
  logic           busy;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(HT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_last(req_last),
    .i_req_data(req_data), .o_ack(ack), .o_byte2send(byte2send),
    .o_tx_start(tx_start), .i_tx_done(tx_done), .o_owner(owner), .o_busy(busy)
  );

  typedef struct { int idx; logic [7:0] data; bit tight; } exp_t;

  logic [8:0] drv_q [N][$];
  logic [8:0] st_q  [N][$];
  exp_t       exp_q [$];
  int         m_rr = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_done_cyc = -100;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Frame-level reference: each grant takes a whole frame from the next non-empty requester after m_rr.
  task automatic model_phase();
    logic [8:0] m [N][$];
    logic [8:0] it;
    bit         tight;
    bit         found;
    int         p;
    for (int i = 0; i < N; i++) m[i] = st_q[i];
    tight = 1'b0;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      p = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (m[(m_rr + k) % N].size() > 0) begin
          found = 1'b1;
          p = (m_rr + k) % N;
        end
      end
      if (found) begin
        it = 9'h0;
        do begin
          it = m[p].pop_front();
          exp_q.push_back('{p, it[7:0], tight});
          tight = 1'b1;
        end while (!it[8] && m[p].size() > 0);
        m_rr = (p + 1) % N;
        if (!it[8]) tight = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      foreach (st_q[i][j]) drv_q[i].push_back(st_q[i][j]);
      st_q[i].delete();
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 2000 && !(exp_q.size() == 0 && !busy && all_empty())) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  // Requesters: present queue head, advance on ack.
  initial begin
    logic [8:0] it;
    req = '0; req_last = '0; req_data = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (rst_n && ack[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          it = drv_q[i][0];
          req[i] = 1'b1;
          req_last[i] = it[8];
          req_data[8*i +: 8] = it[7:0];
        end else begin
          req[i] = 1'b0;
          req_last[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Transmitter stand-in: tx_done 2..6 cycles after each tx_start.
  initial begin
    int cnt;
    cnt = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) tx_done = 1'b1;
        end
        if (tx_start) cnt = $urandom_range(2, 6);
      end
    end
  end

  initial begin
    exp_t e;
    bit   prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (tx_start || ack != 0) chk("ack_with_start", 32'(ack != 0), 32'(tx_start));
        if (tx_start) begin
          chk("start_not_back_to_back", 32'(prev_start), 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got owner %0d byte %0h expected no issue", owner, byte2send);
          end else begin
            e = exp_q.pop_front();
            chk("ack_onehot", 32'(ack), 32'(1) << e.idx);
            chk("byte2send", 32'(byte2send), 32'(e.data));
            chk("owner", 32'(owner), 32'(e.idx));
            if (e.tight) chk("start_gap_after_done", 32'(cyc - last_done_cyc), 2);
          end
        end
        if (tx_done) last_done_cyc = cyc;
      end
      prev_start = tx_start;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nf, nb;
    logic [8:0] it;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ack", 32'(ack), 0);
    chk("reset_tx_start", 32'(tx_start), 0);
    chk("reset_byte2send", 32'(byte2send), 0);
    chk("reset_owner", 32'(owner), 0);
    chk("reset_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // contention 0,1,3 twice, wrap 3 -> 0
    for (int r = 0; r < 2; r++) begin
      st_q[0].push_back({1'b1, 8'h11});
      st_q[1].push_back({1'b1, 8'h22});
      st_q[3].push_back({1'b1, 8'h44});
    end
    model_phase();
    wait_idle("contention_done");

    // single byte with grant latency and busy span
    st_q[0].push_back({1'b1, 8'h9A});
    model_phase();
    n = 0;
    while (!req[0] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("grant_latency_tx_start", 32'(tx_start), 1);
    n = 0;
    while (!tx_done && n < 50) begin @(negedge clk); n++; end
    chk("single_busy_at_done", 32'(busy), 1);
    @(negedge clk);
    chk("single_idle_after_done", 32'(busy), 0);
    wait_idle("single_done");

    // frame lock: requester 2 three bytes while requester 0 waits
    st_q[2].push_back({1'b0, 8'hA1});
    st_q[2].push_back({1'b0, 8'hA2});
    st_q[2].push_back({1'b1, 8'hA3});
    st_q[0].push_back({1'b1, 8'h5E});
    model_phase();
    wait_idle("frame_lock_done");

    // hold timeout: requester 1 abandons its frame, requester 3 waits
    st_q[1].push_back({1'b0, 8'h5C});
    st_q[3].push_back({1'b1, 8'h3D});
    model_phase();
    n = 0;
    while (!tx_done && n < 200) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 50);
    chk("timeout_idle_cycles", 32'(n), 9);
    wait_idle("timeout_done");

    // reset mid-frame, then grant restarts from requester 0
    st_q[1].push_back({1'b1, 8'h77});
    model_phase();
    wait_idle("pre_reset_done");
    st_q[2].push_back({1'b0, 8'hC1});
    st_q[2].push_back({1'b0, 8'hC2});
    st_q[2].push_back({1'b1, 8'hC3});
    model_phase();
    n = 0;
    while (!tx_start && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_ack", 32'(ack), 0);
    chk("async_reset_tx_start", 32'(tx_start), 0);
    chk("async_reset_byte2send", 32'(byte2send), 0);
    chk("async_reset_owner", 32'(owner), 0);
    chk("async_reset_busy", 32'(busy), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) drv_q[i].delete();
    m_rr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st_q[3].push_back({1'b1, 8'hD3});
    st_q[0].push_back({1'b1, 8'hD0});
    model_phase();
    wait_idle("post_reset_done");

    // randomized phases
    for (int ph = 0; ph < 20; ph++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          nf = $urandom_range(1, 2);
          for (int f = 0; f < nf; f++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
              it = {1'(b == nb - 1), 8'($urandom)};
              st_q[i].push_back(it);
            end
          end
        end
      end
      model_phase();
      wait_idle("random_phase_done");
    end

    repeat (20) @(negedge clk);
    chk("expected_queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
